cache_fill_fsm: RTL

- Miss-handling controller between the CPU's instruction/data caches and the multi-cycle unified main memory.
- On a cache miss it fetches one 16-byte block (8 words) from memory and streams each word into the cache data array.
- It then writes the tag, and holds the CPU stalled via fsm_busy for the whole fill.
- It replaces the single-cycle memory path used by the IF and MEM stages.

---
 rtl/cache_pkg.sv | 15 +
 rtl/fill_counter.sv | 34 +++
 rtl/cache_fill_fsm.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss fill controller.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FILL = 2'b01,
      TAG  = 2'b10
   } state_t;

   localparam int          BLOCK_WORDS = 8;
   localparam int          OFFSET_BITS = 4;
   localparam int          CNT_W       = 3;
   localparam logic [15:0] BASE_MASK   = 16'hFFF0;

endpackage

// File: rtl/fill_counter.sv
// Word counter for one block: counts BLOCK_WORDS enabled cycles, then holds with done set.
module fill_counter
   import cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   logic [CNT_W-1:0] r_count;
   logic             r_done;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_done  <= 1'b0;
      end else if (clr) begin
         r_count <= '0;
         r_done  <= 1'b0;
      end else if (en && !r_done) begin
         r_count <= r_count + 1'b1;
         if (r_count == CNT_W'(BLOCK_WORDS - 1))
            r_done <= 1'b1;
      end
   end

   assign count = r_count;
   assign done  = r_done;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one block from pipelined main memory and writes the tag.
// Optional performance counters are enabled with macro CACHE_FILL_PERF_EN.
module cache_fill_fsm
   import cache_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   output logic        fsm_busy,
   output logic        memory_read_en,
   output logic [15:0] memory_address,
   input  logic        memory_data_valid,
   input  logic [15:0] memory_data,
   output logic        write_data_array,
   output logic [2:0]  data_word_sel,
   output logic        write_tag_array,
   output logic [15:0] fill_address
`ifdef CACHE_FILL_PERF_EN
   ,
   output logic [15:0] miss_count,
   output logic [15:0] stall_cycles
`endif
);

   state_t           r_state;
   logic [15:0]      r_base;
   logic             r_busy;
   logic             r_tag;

   logic             w_start;
   logic             w_issue;
   logic             w_write;
   logic             w_last_word;
   logic [CNT_W-1:0] w_issue_cnt;
   logic [CNT_W-1:0] w_recv_cnt;
   logic             w_issue_done;
   logic             w_recv_done;

   assign w_start     = (r_state == IDLE) && miss_detected;
   assign w_issue     = (r_state == FILL) && !w_issue_done;
   assign w_write     = (r_state == FILL) && memory_data_valid && !w_recv_done;
   assign w_last_word = w_write && (w_recv_cnt == CNT_W'(BLOCK_WORDS - 1));

   fill_counter u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_start),
      .en    (w_issue),
      .count (w_issue_cnt),
      .done  (w_issue_done)
   );

   fill_counter u_recv_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_start),
      .en    (w_write),
      .count (w_recv_cnt),
      .done  (w_recv_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_base  <= '0;
         r_busy  <= 1'b0;
         r_tag   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (miss_detected) begin
                  r_base  <= miss_address & BASE_MASK;
                  r_busy  <= 1'b1;
                  r_state <= FILL;
               end
            end
            FILL: begin
               if (w_last_word) begin
                  r_tag   <= 1'b1;
                  r_state <= TAG;
               end
            end
            TAG: begin
               r_tag   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_tag   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Word offset is concatenated, not added, so it can never carry into the block base.
   assign memory_read_en   = w_issue;
   assign memory_address   = w_issue ? {r_base[15:OFFSET_BITS], w_issue_cnt, 1'b0} : 16'h0000;
   assign write_data_array = w_write;
   assign data_word_sel    = w_recv_cnt;
   assign write_tag_array  = r_tag;
   assign fsm_busy         = r_busy;
   assign fill_address     = r_base;

`ifdef CACHE_FILL_PERF_EN
   logic [15:0] r_miss_count;
   logic [15:0] r_stall_cycles;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_miss_count   <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (w_start && (r_miss_count != 16'hFFFF))
            r_miss_count <= r_miss_count + 16'd1;
         if (r_busy && (r_stall_cycles != 16'hFFFF))
            r_stall_cycles <= r_stall_cycles + 16'd1;
      end
   end

   assign miss_count   = r_miss_count;
   assign stall_cycles = r_stall_cycles;
`endif

endmodule
